// File: rtl/serial_adder_core.sv
// Bit-serial adder: sums LSB-first operand streams with a registered carry,
// rebuilds the WIDTH-bit result and flags completion with a one-cycle done.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; bit_valid ignored, result outputs held
// ST_ADD  | consuming one bit pair per bit_valid cycle, gaps hold state
// ST_DONE | single cycle after the final bit; done high, start ignored
module serial_adder_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    // Holds the bits received so far in the upper positions; bit 0 of the
    // full word is only ever needed at the completion edge.
    logic [WIDTH-2:0] sr;

    logic             s_bit;
    logic             c_next;
    logic             take_bit;
    logic             last_bit;
    logic [WIDTH-1:0] word;

    assign s_bit    = a_bit ^ b_bit ^ carry;
    assign c_next   = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    assign word     = {s_bit, sr};
    assign take_bit = (state == ST_ADD) && bit_valid;
    assign last_bit = take_bit && (count == LAST_IDX);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_ADD;
            ST_ADD:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            carry     <= 1'b0;
            count     <= '0;
            sr        <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            carry <= 1'b0;
            count <= '0;
            sr    <= '0;
        end else if (take_bit) begin
            sr    <= word[WIDTH-1:1];
            carry <= c_next;
            count <= count + 1'b1;
            if (last_bit) begin
                sum       <= word;
                carry_out <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_core.sv
// Self-checking bench for serial_adder_core: table vectors from the test plan,
// hand-written corner sequences and randomized operations against a+b.
module tb_serial_adder_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int gap_q [W];

    serial_adder_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        int           gap_at_3;
        int           gap_at_6;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < W; i++) gap_q[i] = 0;
    endtask

    // Runs one addition from the first IDLE cycle; gap_q[i] idle cycles are
    // inserted before bit i. Ends in the first IDLE cycle after DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_s, input logic exp_c,
                          input int start_at_bit, input bit start_in_done);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        for (int i = 0; i < W; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                bit_valid = 1'b0;
                a_bit = 1'($urandom);
                b_bit = 1'($urandom);
                step();
                chk("done_in_gap", done, 1'b0);
            end
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            start = (i == start_at_bit);
            step();
            start = 1'b0;
            if (i < W - 1) chk("done_early", done, 1'b0);
        end
        bit_valid = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_in_done", busy, 1'b1);
        chk("sum", sum, exp_s);
        chk("carry_out", carry_out, exp_c);
        start = start_in_done;
        step();
        start = 1'b0;
        chk("done_cleared", done, 1'b0);
        chk("busy_dropped", busy, 1'b0);
        if (start_in_done) begin
            step();
            chk("no_restart_busy", busy, 1'b0);
            chk("sum_held", sum, exp_s);
        end
    endtask

    vec_t vecs [4];

    initial begin
        logic [W-1:0] held_s;
        logic         held_c;
        logic [W:0]   ref_r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1, gap_at_3: 0, gap_at_6: 0};
        vecs[1] = '{a: 8'h5A, b: 8'h25, s: 8'h7F, c: 1'b0, gap_at_3: 3, gap_at_6: 1};
        vecs[2] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, gap_at_3: 0, gap_at_6: 0};
        vecs[3] = '{a: 8'h01, b: 8'h01, s: 8'h02, c: 1'b0, gap_at_3: 0, gap_at_6: 0};

        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst_sum", sum, '0);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Entries 2 and 3 run back-to-back: run_op returns in the first IDLE cycle.
        for (int v = 0; v < 4; v++) begin
            clear_gaps();
            gap_q[3] = vecs[v].gap_at_3;
            gap_q[6] = vecs[v].gap_at_6;
            run_op(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].c, -1, 1'b0);
        end

        // start pulsed mid-ADD and during DONE must not restart anything
        clear_gaps();
        run_op(8'h0F, 8'h01, 8'h10, 1'b0, 4, 1'b1);

        // reset after bit 4 of 0xAA+0x55 aborts and clears the result
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a_bit = ra_bit(8'hAA, i);
            b_bit = ra_bit(8'h55, i);
            step();
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, '0);
        chk("abort_carry", carry_out, 1'b0);
        chk("abort_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a_bit = 1'b1;
            b_bit = 1'b1;
            step();
            chk("abort_no_done", done, 1'b0);
        end
        bit_valid = 1'b0;
        clear_gaps();
        run_op(8'h03, 8'h04, 8'h07, 1'b0, -1, 1'b0);

        // bit_valid activity in IDLE without start
        held_s = sum;
        held_c = carry_out;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'($urandom);
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
            step();
            chk("idle_done", done, 1'b0);
        end
        bit_valid = 1'b0;
        chk("idle_sum_held", sum, held_s);
        chk("idle_carry_held", carry_out, held_c);

        // randomized operations with random gaps and idle spacing
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ref_r = {1'b0, ra} + {1'b0, rb};
            for (int i = 0; i < W; i++)
                gap_q[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(ra, rb, ref_r[W-1:0], ref_r[W], -1, 1'b0);
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic ra_bit(input logic [W-1:0] v, input int i);
        return v[i];
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder_core.md
# serial_adder_core

Bit-serial adder stage that consumes the LSB-first operand bit streams produced by the parallel-to-serial shift register. It adds one bit pair per valid cycle using a registered carry, deserialises the sum back into a WIDTH-bit word, and reports completion with a one-cycle `done` pulse. It sits directly downstream of the operand serialiser and is sequenced by a start/valid handshake from the controlling logic.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2 to 32.

- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request a new addition; sampled only in IDLE.
- `bit_valid`  input  1  `a_bit`/`b_bit` carry a valid bit pair this cycle.
- `a_bit`  input  1  serial operand A bit, LSB first.
- `b_bit`  input  1  serial operand B bit, LSB first.
- `sum`  output  WIDTH  last completed sum word; held until the next completion.
- `carry_out`  output  1  carry out of the MSB for the last completed addition.
- `busy`  output  1  high in ADD and DONE.
- `done`  output  1  one-cycle pulse when `sum`/`carry_out` update.

## Operation
- **States:** IDLE, ADD, DONE (registered FSM).
- **IDLE**
  - `busy`=0. `bit_valid` is ignored.
  - `start`=1 → ADD. On that edge: internal carry ← 0, bit counter ← 0, sum shift register ← 0.
- **ADD**
  - Each edge with `bit_valid`=1:
    - s = a^b^c; c_next = (a&b)|(a&c)|(b&c).
    - Shift register ← {s, sr[WIDTH-1:1]} (LSB arrives first and ends at bit 0).
    - c ← c_next; count ← count+1.
  - `bit_valid`=0: everything holds. Gaps of any length are legal.
  - On the edge that samples valid bit number WIDTH (count == WIDTH-1):
    - `sum` ← {s, sr[WIDTH-1:1]}; `carry_out` ← c_next; `done` ← 1.
    - State → DONE.
- **DONE**
  - Lasts exactly one cycle; `done`=1 during it.
  - Next edge: `done` ← 0, state → IDLE.
  - `start` and `bit_valid` are ignored in this state.
- `start` while in ADD or DONE is ignored; it does not restart the addition.
- Arithmetic is modulo 2^WIDTH; the true result is {`carry_out`, `sum`}.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps during an operation.
- `sum` and `carry_out` change only on a completion edge or on reset.
- **Integration:** the upstream serialiser presents bit i one cycle after the enable edge that shifts it. The controller drives `bit_valid` as that enable delayed by one cycle.

## Timing
- **Reset** (`reset_n`=0 at an edge): state IDLE; `sum`=0, `carry_out`=0, `done`=0, `busy`=0; internal carry, counter and shift register = 0.
- **Reset mid-operation:** aborts the addition. No `done` pulse. Previous `sum` is cleared to 0.
- **Start sampling:** `start` sampled at edge t0 → `busy`=1 from t0+; the first bit can be sampled at t0+1.
- **Latency:** with `bit_valid` held high, bits are sampled at edges t0+1 … t0+WIDTH. `done` and the new `sum` are visible in the cycle after edge t0+WIDTH. `busy` drops after edge t0+WIDTH+1.
- **Back-to-back operation:** the earliest next `start` is sampled at edge t0+WIDTH+2 (first IDLE cycle). Throughput is one addition per WIDTH+2 cycles.
- **Gaps:** each cycle with `bit_valid`=0 adds one cycle to the latency.

## Test plan
- Reset, start, stream A=0xFF, B=0xFF LSB-first with `bit_valid` continuous → `done` one cycle after 8th bit edge, `sum`=0xFE, `carry_out`=1, `busy` low one cycle later.
- A=0x5A, B=0x25, `bit_valid` deasserted for 3 cycles after bit 2 and 1 cycle after bit 5 → `sum`=0x7F, `carry_out`=0, `done` delayed by exactly 4 cycles relative to the continuous case.
- Two back-to-back ops: 0x80+0x80 then 0x01+0x01, second `start` at the first IDLE cycle → first `sum`=0x00/`carry_out`=1, second `sum`=0x02/`carry_out`=0. Confirms carry is cleared between ops.
- `start` pulsed during ADD (after bit 3) and during DONE → ignored; result of 0x0F+0x01 is `sum`=0x10, `carry_out`=0 with a single `done` pulse.
- `reset_n` low for one cycle after bit 4 of 0xAA+0x55 → no `done`; `sum`=0, `carry_out`=0, `busy`=0. A subsequent 0x03+0x04 completes with `sum`=0x07.
- `bit_valid` toggled in IDLE with random bits, no `start` → `sum`/`carry_out` unchanged and `done` never asserts.
